// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared definitions for the unified-memory port arbiter:
//   - default address / data word sizes (MSB indices, so widths are +1)
//   - arbiter FSM state encodings
//   - owner IDs used by the round-robin priority pointer
//
// Optional feature macro used by the importing files: ARB_ROUND_ROBIN_EN
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // MSB indices: an address is DEF_ADDR_SIZE+1 bits, a data word
    // DEF_INSTR_SIZE+1 bits.
    localparam int DEF_ADDR_SIZE  = 31;
    localparam int DEF_INSTR_SIZE = 31;

    // Byte-enable width of the memory port.
    localparam int WSTRB_W = 4;

    // Arbiter FSM state encodings.
    localparam logic [1:0] ARB_IDLE   = 2'd0;  // nothing in flight
    localparam logic [1:0] ARB_BUSY_I = 2'd1;  // fetch in flight
    localparam logic [1:0] ARB_BUSY_D = 2'd2;  // load/store in flight
    localparam logic [1:0] ARB_DRAIN  = 2'd3;  // aborted fetch still at memory

    // Owner IDs. The priority pointer holds the owner that wins a tie.
    localparam logic OWNER_D = 1'b0;
    localparam logic OWNER_I = 1'b1;

    // Owner that should get priority after 'granted' was served.
    function automatic logic other_owner(input logic granted);
        return ~granted;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
//
// Combinational priority pick between the fetch and load/store requests.
// At most one grant output is high, and only for an asserted request.
//
// Ports:
//   req_i   in   fetch request (already masked by the caller)
//   req_d   in   load/store request (already masked by the caller)
//   prio    in   owner that wins a tie (only with ARB_ROUND_ROBIN_EN)
//   gnt_i   out  grant to fetch
//   gnt_d   out  grant to load/store
//
// Macro ARB_ROUND_ROBIN_EN: defined -> tie goes to the owner named by prio;
// undefined -> the data port always wins a tie.
// -----------------------------------------------------------------------------
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic prio,
`endif
    output logic gnt_i,
    output logic gnt_d
);

`ifdef ARB_ROUND_ROBIN_EN
    // Data wins when fetch is idle or data holds the priority token.
    assign gnt_d = req_d & (~req_i | (prio == OWNER_D));
`else
    // Fixed priority: data always wins, fetch can starve.
    assign gnt_d = req_d;
`endif
    assign gnt_i = req_i & ~gnt_d;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-ported unified memory between the fetch read port and
// the load/store port. One memory transaction is in flight at a time; the
// response is registered and routed back to its owner with a one-cycle
// ready strobe. A fetch whose enable drops while in flight is drained at
// the memory and its response discarded.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   i_rd_enable/i_rd_addr      fetch request (level) and address
//   i_rd_data/i_rd_ready       fetch response data and one-cycle strobe
//   d_enable/d_we/d_addr       load/store request (level), store flag, addr
//   d_wdata/d_wstrb            store data and byte enables
//   d_rdata/d_ready            load data and one-cycle strobe (also for stores)
//   mem_req/mem_we/mem_addr    memory request (held until mem_ready), command
//   mem_wdata/mem_wstrb        memory write data and byte enables
//   mem_rdata/mem_ready        memory read data and completion strobe
//
// Macros:
//   ARB_ROUND_ROBIN_EN  tie between ports goes to the one not granted last
//                       (pointer resets to data); otherwise data always wins.
//   SIMULATE            print a warning when mem_ready arrives while idle.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int INSTR_SIZE = DEF_INSTR_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_rd_enable,
    input  logic [ADDR_SIZE:0]    i_rd_addr,
    output logic [INSTR_SIZE:0]   i_rd_data,
    output logic                  i_rd_ready,

    input  logic                  d_enable,
    input  logic                  d_we,
    input  logic [ADDR_SIZE:0]    d_addr,
    input  logic [INSTR_SIZE:0]   d_wdata,
    input  logic [WSTRB_W-1:0]    d_wstrb,
    output logic [INSTR_SIZE:0]   d_rdata,
    output logic                  d_ready,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_SIZE:0]    mem_addr,
    output logic [INSTR_SIZE:0]   mem_wdata,
    output logic [WSTRB_W-1:0]    mem_wstrb,
    input  logic [INSTR_SIZE:0]   mem_rdata,
    input  logic                  mem_ready
);

    logic [1:0] state;
    logic       req_i;
    logic       req_d;
    logic       gnt_i;
    logic       gnt_d;

    // A requester holds enable through the cycle its ready strobe is high
    // and drops it on the following edge, so that cycle is not a request.
    assign req_i = i_rd_enable & ~i_rd_ready;
    assign req_d = d_enable & ~d_ready;

`ifdef ARB_ROUND_ROBIN_EN
    logic prio;  // owner that wins the next tie

    arb_pick u_pick (
        .req_i (req_i),
        .req_d (req_d),
        .prio  (prio),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );
`else
    arb_pick u_pick (
        .req_i (req_i),
        .req_d (req_d),
        .gnt_i (gnt_i),
        .gnt_d (gnt_d)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            i_rd_data  <= '0;
            i_rd_ready <= 1'b0;
            d_rdata    <= '0;
            d_ready    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            prio       <= OWNER_D;
`endif
        end else begin
            // Ready strobes are single-cycle by default.
            i_rd_ready <= 1'b0;
            d_ready    <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    // mem_ready here is a stray strobe and is ignored.
                    if (gnt_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_wstrb;
                        state     <= ARB_BUSY_D;
`ifdef ARB_ROUND_ROBIN_EN
                        prio      <= other_owner(OWNER_D);
`endif
                    end else if (gnt_i) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_rd_addr;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        state     <= ARB_BUSY_I;
`ifdef ARB_ROUND_ROBIN_EN
                        prio      <= other_owner(OWNER_I);
`endif
                    end
                end

                ARB_BUSY_I: begin
                    // Completion wins over an enable that drops in the same
                    // cycle: the data is already on its way back.
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        i_rd_data  <= mem_rdata;
                        i_rd_ready <= 1'b1;
                        state      <= ARB_IDLE;
                    end else if (!i_rd_enable) begin
                        state      <= ARB_DRAIN;
                    end
                end

                ARB_BUSY_D: begin
                    // d_enable is not watched: data requests cannot abort.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        d_rdata <= mem_rdata;
                        d_ready <= 1'b1;
                        state   <= ARB_IDLE;
                    end
                end

                ARB_DRAIN: begin
                    // Memory still owes a response to the aborted fetch;
                    // swallow it without touching i_rd_data.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= ARB_IDLE;
                    end
                end

                default: begin
                    mem_req <= 1'b0;
                    state   <= ARB_IDLE;
                end
            endcase
        end
    end

`ifdef SIMULATE
    always @(posedge clk) begin
        if (reset && (state == ARB_IDLE) && mem_ready)
            $display("mem_port_arbiter: warning: mem_ready ignored while idle at %0t", $time);
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported unified memory between the fetch stage's read port and the memory stage's load/store port. The block sits between the pipeline and the memory model. It serialises requests, issues exactly one memory transaction at a time, and routes each response back to its owner. It also absorbs fetch aborts caused by pipeline flushes.

## Interface
Parameters:
- `ADDR_SIZE`, from the shared include. MSB index of addresses, so addresses are `ADDR_SIZE+1` bits wide.
- `INSTR_SIZE`, from the shared include. MSB index of the data word, so data words are `INSTR_SIZE+1` bits (32) wide.

Ports:
- `clk` input 1: the single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `i_rd_enable` input 1: fetch read request, level.
- `i_rd_addr` input `ADDR_SIZE+1`: fetch address.
- `i_rd_data` output `INSTR_SIZE+1`: fetch read data.
- `i_rd_ready` output 1: fetch response strobe, one cycle.
- `d_enable` input 1: load/store request, level.
- `d_we` input 1: 1 = store.
- `d_addr` input `ADDR_SIZE+1`: load/store address.
- `d_wdata` input `INSTR_SIZE+1`: store data.
- `d_wstrb` input 4: byte enables for a store.
- `d_rdata` output `INSTR_SIZE+1`: load data.
- `d_ready` output 1: load/store response strobe, one cycle.
- `mem_req` output 1: memory request, held until accepted.
- `mem_we` output 1: memory write enable.
- `mem_addr` output `ADDR_SIZE+1`: memory address.
- `mem_wdata` output `INSTR_SIZE+1`: memory write data.
- `mem_wstrb` output 4: memory byte enables.
- `mem_rdata` input `INSTR_SIZE+1`: memory read data.
- `mem_ready` input 1: memory completion strobe, one cycle.

## Operation
- FSM states:
  - `IDLE`: no transaction in flight.
  - `BUSY_I`: fetch transaction in flight.
  - `BUSY_D`: load/store transaction in flight.
  - `DRAIN`: aborted fetch still in flight at the memory.
- Leaving `IDLE`:
  - With one requester pending (enable high), grant it.
  - On a grant, register `mem_req`=1 and latch that requester's address, we, wdata and wstrb into the `mem_*` outputs.
  - Go to `BUSY_I` or `BUSY_D`.
- Fetch requests always drive `mem_we`=0 and `mem_wstrb`=0.
- `mem_*` outputs stay stable while `mem_req`=1. Requester inputs are not re-sampled during that time.
- In `BUSY_x`, on `mem_ready`:
  - Clear `mem_req`.
  - Register `mem_rdata` into the owner's `*_rdata`/`*_rd_data`.
  - Pulse the owner's ready output for one cycle.
  - Return to `IDLE`.
- Store responses also pulse `d_ready`. `d_rdata` is undefined for a store.
- Fetch abort:
  - If `i_rd_enable` falls in `BUSY_I` before `mem_ready`, go to `DRAIN`.
  - In `DRAIN`, on `mem_ready`: clear `mem_req`, suppress `i_rd_ready`, leave `i_rd_data` unchanged, go to `IDLE`.
- Data requests cannot be aborted. `d_enable` must hold until `d_ready`, and dropping it early is a protocol error the block ignores.
- Request masking:
  - A requester's enable is ignored in the cycle its ready output is high, because the requester drops enable on that edge.
  - Enable high in any later cycle is a new request.
- Simultaneous requests in `IDLE` are resolved per Configuration.
- Reset (asynchronous, any state) forces:
  - state = `IDLE`
  - `mem_req`, `mem_we`, `i_rd_ready`, `d_ready` = 0
  - `mem_addr`, `mem_wdata`, `mem_wstrb`, `i_rd_data`, `d_rdata` = 0
  - priority pointer = data
- A transaction in flight at reset is abandoned. A `mem_ready` arriving after release in `IDLE` is ignored.

## Timing
- Grant latency: a request seen at edge N gives `mem_req`=1 after edge N.
- Response latency: `mem_ready` sampled at edge M gives the owner's ready and data valid in cycle M+1.
- Back-to-back: the earliest next `mem_req` is asserted after edge M+1, giving one bubble cycle between transactions.
- Fetch best case with single-cycle memory: enable at edge 0, `mem_req` in cycle 1, `mem_ready` in cycle 1, `i_rd_ready` in cycle 2.
- `mem_ready` seen in `IDLE`: ignored. Under `SIMULATE`, display a warning.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - Defined: a one-bit pointer gives priority to the requester not most recently granted. The pointer flips on every grant and resets to data.
  - Undefined: fixed priority, the data port always wins ties, and fetch may starve while the data port keeps requesting.

## Structure
- State encodings (`ARB_IDLE`, `ARB_BUSY_I`, `ARB_BUSY_D`, `ARB_DRAIN`) and owner IDs go in `def_params.v`, alongside `ADDR_SIZE`/`INSTR_SIZE`.
- One sub-module, `arb_pick`: combinational priority pick from the two requests plus the pointer. It gives the fixed or round-robin variant under the macro.

## Test plan
- Fetch only, memory ready after 3 cycles, addr 0x10 → `mem_addr`=0x10 with `mem_we`=0; `i_rd_ready` one cycle with `i_rd_data`=`mem_rdata`; `d_ready` stays 0.
- Store only, addr 0x20, wdata 0xDEADBEEF, wstrb 0xF → `mem_we`=1 and `mem_wdata`=0xDEADBEEF held until `mem_ready`; one `d_ready` pulse.
- Both requests in the same cycle, macro undefined → data granted first, fetch second, one bubble between.
- Same stimulus with the macro defined, run twice in sequence → grants go D, I, D, I.
- Fetch granted, `i_rd_enable` dropped 1 cycle later, `mem_ready` 4 cycles later → no `i_rd_ready`; a pending load is granted the cycle after `mem_ready`.
- Reset pulled low while in `BUSY_D` → all outputs 0 immediately; after release, a stray `mem_ready` produces no ready pulse.
